// File: rtl/button_pkg.sv
// Shared types and helpers for the button conditioner and its per-channel logic.
package button_pkg;

    // Per-channel press-tracking state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } btn_state_e;

    // Bits needed for a counter that must be able to hold the value max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One conditioner channel: sample-tick debouncer followed by the press/long/repeat FSM.
// The FSM acts on the registered level, so every pulse lands one cycle after the level edge.
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned PULSE_CNT_MAX  = 200,
    parameter int unsigned LONG_CNT_MAX   = 2000,
    parameter int unsigned REPEAT_CNT_MAX = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic sync_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic long_pulse_o,
    output logic repeat_pulse_o
);

    localparam int unsigned DCNT_W   = cnt_width(PULSE_CNT_MAX);
    localparam int unsigned HOLD_MAX = (LONG_CNT_MAX > REPEAT_CNT_MAX) ? LONG_CNT_MAX : REPEAT_CNT_MAX;
    localparam int unsigned HCNT_W   = cnt_width(HOLD_MAX);

    localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(PULSE_CNT_MAX - 1);
    localparam logic [HCNT_W-1:0] LONG_LAST   = HCNT_W'(LONG_CNT_MAX - 1);
    localparam logic [HCNT_W-1:0] REPEAT_LAST = HCNT_W'(REPEAT_CNT_MAX - 1);

    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              level_q, level_d;
    logic              level_fall;

    btn_state_e        state_q;
    logic [HCNT_W-1:0] hcnt_q;
    logic              press_q, release_q, long_q, repeat_q;

    // Debounce next state: count disagreeing samples, flip level on the last one.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        dcnt_d  = dcnt_q;
        level_d = level_q;
        if (tick_i) begin
            if (sync_i == level_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == DCNT_LAST) begin
                level_d = ~level_q;
                dcnt_d  = '0;
            end else begin
                dcnt_d = dcnt_q + DCNT_W'(1);
            end
        end
    end

    // A fall being committed on this tick must pre-empt any long/repeat pulse due now.
    assign level_fall = level_q & ~level_d;

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dcnt_q  <= '0;
            level_q <= 1'b0;
        end else begin
            dcnt_q  <= dcnt_d;
            level_q <= level_d;
        end
    end

    // Press-tracking FSM with hold counter and registered one-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (level_q) begin
                        state_q <= HELD;
                        hcnt_q  <= '0;
                        press_q <= 1'b1;
                    end
                end
                HELD: begin
                    if (!level_q) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                    end else if (tick_i && !level_fall) begin
                        if (hcnt_q == LONG_LAST) begin
                            hcnt_q  <= '0;
                            long_q  <= 1'b1;
                            state_q <= LONG;
                        end else begin
                            hcnt_q <= hcnt_q + HCNT_W'(1);
                        end
                    end
                end
                LONG: begin
                    if (!level_q) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                    end else if (tick_i && !level_fall) begin
                        // The cadence keeps running while repeat is disabled; only the pulse is gated.
                        if (hcnt_q == REPEAT_LAST) begin
                            hcnt_q   <= '0;
                            repeat_q <= repeat_en_i;
                        end else begin
                            hcnt_q <= hcnt_q + HCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    hcnt_q  <= '0;
                end
            endcase
        end
    end

    assign level_o         = level_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign long_pulse_o    = long_q;
    assign repeat_pulse_o  = repeat_q;

endmodule

// File: rtl/synchronizer.sv
// Multi-bit flip-flop chain that brings asynchronous inputs into the clk domain.
// Each bit is synchronised independently; there is no cross-bit coherence.
module synchronizer #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    // Shift the raw inputs through STAGES flops; stage 0 is the metastable one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the stages are cleared so the debouncer starts from a known 0 rather than X.
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end: synchroniser, shared sample tick, and one
// debounce/press-decode channel per input.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SAMPLE_CNT_MAX = 33750,
    parameter int unsigned PULSE_CNT_MAX  = 200,
    parameter int unsigned LONG_CNT_MAX   = 2000,
    parameter int unsigned REPEAT_CNT_MAX = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] repeat_en,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_pulse,
    output logic [WIDTH-1:0] repeat_pulse
);

    localparam int unsigned       TICK_W    = cnt_width(SAMPLE_CNT_MAX);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CNT_MAX - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [WIDTH-1:0]  sync;

    synchronizer #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (in),
        .q_o   (sync)
    );

    // With SAMPLE_CNT_MAX = 1 the counter sits at 0 and tick is high every cycle.
    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    // Shared sample-tick counter, wrapping on the tick cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        button_channel #(
            .PULSE_CNT_MAX  (PULSE_CNT_MAX),
            .LONG_CNT_MAX   (LONG_CNT_MAX),
            .REPEAT_CNT_MAX (REPEAT_CNT_MAX)
        ) u_chan (
            .clk             (clk),
            .rst_n           (rst),
            .tick_i          (tick),
            .sync_i          (sync[i]),
            .repeat_en_i     (repeat_en[i]),
            .level_o         (level[i]),
            .press_pulse_o   (press_pulse[i]),
            .release_pulse_o (release_pulse[i]),
            .long_pulse_o    (long_pulse[i]),
            .repeat_pulse_o  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with SAMPLE=4, PULSE=3, LONG=10, REPEAT=5.
// Inputs are driven and outputs sampled on the falling edge; latencies are counted
// in falling edges from the drive point.
module tb_button_conditioner;

    localparam int W = 4;
    localparam int K_LEVEL   = 0;
    localparam int K_PRESS   = 1;
    localparam int K_RELEASE = 2;
    localparam int K_LONG    = 3;
    localparam int K_REPEAT  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_r;
    logic [W-1:0] repeat_en_r;
    logic [W-1:0] level, press_pulse, release_pulse, long_pulse, repeat_pulse;

    int checks = 0;
    int errors = 0;
    int press_cnt   [W] = '{default: 0};
    int release_cnt [W] = '{default: 0};
    int long_cnt    [W] = '{default: 0};
    int repeat_cnt  [W] = '{default: 0};

    button_conditioner #(
        .WIDTH          (W),
        .SYNC_STAGES    (2),
        .SAMPLE_CNT_MAX (4),
        .PULSE_CNT_MAX  (3),
        .LONG_CNT_MAX   (10),
        .REPEAT_CNT_MAX (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in            (in_r),
        .repeat_en     (repeat_en_r),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    // Tally every pulse cycle seen just before each rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
            if (press_pulse[i]   === 1'b1) press_cnt[i]++;
            if (release_pulse[i] === 1'b1) release_cnt[i]++;
            if (long_pulse[i]    === 1'b1) long_cnt[i]++;
            if (repeat_pulse[i]  === 1'b1) repeat_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic probe(input int kind, input int ch);
        case (kind)
            K_LEVEL:   return level[ch];
            K_PRESS:   return press_pulse[ch];
            K_RELEASE: return release_pulse[ch];
            K_LONG:    return long_pulse[ch];
            default:   return repeat_pulse[ch];
        endcase
    endfunction

    // Falling edges until the probed output equals want; -1 if the budget runs out.
    task automatic wait_sig(input int kind, input int ch, input logic want, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (probe(kind, ch) === want) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int p0;
        int p3;

        // Reset state
        rst = 1'b0;
        in_r = '0;
        repeat_en_r = '0;
        cycles(3);
        check("reset_level", 32'(level), 32'd0);
        check("reset_pulses", 32'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 32'd0);
        rst = 1'b1;
        cycles(3);

        // Clean press and release on channel 0: debounce window is 2+8+1 .. 2+12
        in_r[0] = 1'b1;
        wait_sig(K_LEVEL, 0, 1'b1, 30, n);
        check_range("press0_latency", n, 11, 14);
        check("press0_not_with_level", 32'(press_pulse[0]), 32'd0);
        cycles(1);
        check("press0_pulse", 32'(press_pulse), 32'b0001);
        cycles(1);
        check("press0_width", 32'(press_pulse[0]), 32'd0);
        cycles(5);
        check("press0_count", press_cnt[0], 1);
        check("others_level_quiet", 32'(level[3:1]), 32'd0);
        check("others_pulses_quiet", press_cnt[1] + press_cnt[2] + press_cnt[3]
              + release_cnt[1] + release_cnt[2] + release_cnt[3], 0);
        in_r[0] = 1'b0;
        wait_sig(K_LEVEL, 0, 1'b0, 30, n);
        check_range("release0_latency", n, 11, 14);
        cycles(1);
        check("release0_pulse", 32'(release_pulse), 32'b0001);
        cycles(3);
        check("release0_count", release_cnt[0], 1);
        check("short_hold_no_long", long_cnt[0], 0);

        // Glitch rejection: 3-cycle pulses at a 13-cycle spacing hit every tick phase
        for (int g = 0; g < 4; g++) begin
            in_r[1] = 1'b1;
            cycles(3);
            in_r[1] = 1'b0;
            cycles(10);
        end
        cycles(20);
        check("glitch_level", 32'(level[1]), 32'd0);
        check("glitch_pulses", press_cnt[1] + release_cnt[1], 0);

        // Long press with repeat on channel 2: long 39 edges after press, repeats every 20
        repeat_en_r[2] = 1'b1;
        in_r[2] = 1'b1;
        wait_sig(K_PRESS, 2, 1'b1, 30, n);
        check_range("press2_latency", n, 12, 15);
        wait_sig(K_LONG, 2, 1'b1, 60, n);
        check("long2_delay", n, 39);
        cycles(1);
        check("long2_width", 32'(long_pulse[2]), 32'd0);
        wait_sig(K_REPEAT, 2, 1'b1, 40, n);
        check("repeat2_first", n, 19);
        wait_sig(K_REPEAT, 2, 1'b1, 40, n);
        check("repeat2_second", n, 20);
        repeat_en_r[2] = 1'b0;
        cycles(25);
        check("repeat2_disabled", repeat_cnt[2], 2);
        repeat_en_r[2] = 1'b1;
        wait_sig(K_REPEAT, 2, 1'b1, 40, n);
        check("repeat2_resume_cadence", n, 15);
        check("long2_count", long_cnt[2], 1);

        // Release priority: drop in[2] 8 edges after a repeat so the fall lands on the next repeat tick
        cycles(8);
        in_r[2] = 1'b0;
        wait_sig(K_LEVEL, 2, 1'b0, 30, n);
        check("prio_fall_latency", n, 12);
        check("prio_no_repeat", 32'(repeat_pulse[2]), 32'd0);
        cycles(1);
        check("prio_release", 32'(release_pulse[2]), 32'd1);
        check("prio_no_repeat_next", 32'(repeat_pulse[2]), 32'd0);
        cycles(40);
        check("prio_repeat_count", repeat_cnt[2], 3);
        check("prio_release_count", release_cnt[2], 1);

        // Long press without repeat on channel 1
        repeat_en_r[1] = 1'b0;
        in_r[1] = 1'b1;
        wait_sig(K_PRESS, 1, 1'b1, 30, n);
        check_range("press1_latency", n, 12, 15);
        wait_sig(K_LONG, 1, 1'b1, 60, n);
        check("long1_delay", n, 39);
        cycles(50);
        check("norepeat1_count", repeat_cnt[1], 0);
        in_r[1] = 1'b0;
        wait_sig(K_LEVEL, 1, 1'b0, 30, n);
        check_range("release1_latency", n, 11, 14);
        cycles(2);

        // Reset mid-press on channel 3
        in_r[3] = 1'b1;
        wait_sig(K_LEVEL, 3, 1'b1, 30, n);
        check_range("press3_latency", n, 11, 14);
        cycles(2);
        rst = 1'b0;
        cycles(1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_pulses", 32'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 32'd0);
        cycles(1);
        rst = 1'b1;
        // Tick counter restarts: ticks fall on edges 3, 7, 11 after release; press one edge after level
        wait_sig(K_PRESS, 3, 1'b1, 30, n);
        check("rst_repress_latency", n, 13);
        cycles(2);
        check("rst_press_count", press_cnt[3], 2);
        check("rst_no_release", release_cnt[3], 0);

        // Simultaneous channels 0 and 3
        in_r[3] = 1'b0;
        wait_sig(K_LEVEL, 3, 1'b0, 30, n);
        check_range("release3_latency", n, 11, 14);
        cycles(3);
        check("release3_count", release_cnt[3], 1);
        in_r[0] = 1'b1;
        in_r[3] = 1'b1;
        p0 = -1;
        p3 = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (p0 < 0 && press_pulse[0] === 1'b1) p0 = k;
            if (p3 < 0 && press_pulse[3] === 1'b1) p3 = k;
            if (p0 >= 0 && p3 >= 0) break;
        end
        check_range("sim_press0_latency", p0, 12, 15);
        check("sim_press3_matches", p3, p0);
        cycles(2);
        in_r[0] = 1'b0;
        wait_sig(K_LEVEL, 0, 1'b0, 30, n);
        check_range("sim_release0_latency", n, 11, 14);
        check("sim_level3_held", 32'(level[3]), 32'd1);
        cycles(1);
        check("sim_release_only0", 32'(release_pulse), 32'b0001);
        in_r[3] = 1'b0;
        wait_sig(K_LEVEL, 3, 1'b0, 30, n);
        check_range("sim_release3_latency", n, 11, 14);
        cycles(1);
        check("sim_release_only3", 32'(release_pulse), 32'b1000);
        cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
